instr_fetch_unit: RTL

Front-end fetch stage of the RISC-V core. It owns the program counter and issues word reads to instruction memory over a single-outstanding request/response interface. It holds the returned instruction for the decode/extend stage with a valid/ready handshake. Taken branches and jumps from execute redirect the PC and squash any in-flight fetch.

---
 rtl/instr_fetch_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Front-end fetch stage. Owns the program counter and issues
//               word reads to instruction memory over a single-outstanding
//               request/response interface. The returned instruction is held
//               for decode with a valid/ready handshake. A redirect from
//               execute (taken branch or jump) retargets the PC and squashes
//               any fetch still in flight.
//
// Ports
//   clk             in   1   system clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   redirect_valid  in   1   one-cycle pulse, taken branch/jump
//   redirect_pc     in  32   redirect target, bits [1:0] ignored
//   imem_req        out  1   read request, one cycle per fetch
//   imem_addr       out 32   word address of the request
//   imem_rvalid     in   1   read data valid
//   imem_rdata      in  32   instruction word
//   instr           out 32   held instruction (NOP_INSTR when not valid)
//   instr_valid     out  1   instr / instr_pc valid
//   instr_ready     in   1   consumer accepts when valid && ready
//   instr_pc        out 32   PC of the held instruction
//   pc_plus4        out 32   instr_pc + 4, wraps mod 2^32
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4
);

    // S_REQ  : request may be issued this cycle
    // S_WAIT : request outstanding, waiting for its response
    // S_HOLD : instruction held for the consumer
    // S_DROP : outstanding response was squashed by a redirect; swallow it
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] redirect_target;
    logic        accept;
    logic        unused_redirect_lsbs;

    // Instruction addresses are always word aligned; the low target bits
    // from execute carry no information here.
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign accept = instr_valid_q && instr_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            S_REQ: begin
                // A redirect here suppresses the request so the stale
                // address never reaches memory. Any rvalid seen in this
                // state is spurious and deliberately ignored.
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    // The response belongs to the squashed path. If it is
                    // arriving right now it is simply dropped; otherwise
                    // wait for it in S_DROP so it cannot be mistaken for
                    // the response to the next request.
                    fetch_pc_d = redirect_target;
                    state_d    = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end

            S_HOLD: begin
                // Redirect has priority over a same-cycle accept: the held
                // instruction is on the wrong path either way, and the
                // sequential PC must not be used.
                if (redirect_valid) begin
                    fetch_pc_d    = redirect_target;
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = S_REQ;
                end else if (accept) begin
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = S_REQ;
                end
            end

            S_DROP: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The state register already sits in S_REQ during reset, so the
    // request is gated by rst_n to keep memory quiet until release.
    assign imem_req    = rst_n && (state_q == S_REQ) && !redirect_valid;
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_valid_q ? instr_q : NOP_INSTR;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + 32'd4;

endmodule
`default_nettype wire
